// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef logic [$clog2(WORD_BYTES)-1:0] byte_idx_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_FIN
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;

   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input byte_ready);
   modport slave  (input byte_in, input byte_valid, output byte_ready);

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Shifts stream bytes MSB-first into an instruction word; full marks the byte
// that completes the word.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    shift,
   input  logic [7:0]              din,
   output logic [8*WORD_BYTES-1:0] word,
   output logic                    full
);

   byte_idx_t cnt;

   assign full = shift && (cnt == byte_idx_t'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
         cnt  <= '0;
      end else if (clear) begin
         word <= '0;
         cnt  <= '0;
      end else if (shift) begin
         word <= {word[8*WORD_BYTES-9:0], din};
         cnt  <= cnt + byte_idx_t'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds fetch
// while loading. Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   imem_loader_if.slave bs,
   output logic         wr_en,
   output logic [31:0]  wr_addr,
   output logic [31:0]  wr_data,
   output logic         busy,
   output logic         fetch_hold,
   output logic         done,
   output logic         err,
   output logic [15:0]  word_count
);

   localparam int          LEN_W   = 8 * LEN_BYTES;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_in;
   logic             go, xfer, asm_shift, asm_full, last_word;
   logic             fin_err, enter_fin, chk_st;

   assign go        = (state == S_IDLE) && start;
   assign xfer      = bs.byte_valid && bs.byte_ready;
   assign len_in    = {len[LEN_W-1:8], bs.byte_in};
   assign asm_shift = xfer && (state == S_DATA);
   assign last_word = (word_count + 16'd1) == len;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_TAIL = S_CHK;
   logic [7:0] csum;

   assign chk_st = (state == S_CHK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    csum <= 8'h00;
      else if (go)   csum <= 8'h00;
      else if (xfer) csum <= csum ^ bs.byte_in;
   end
`else
   localparam state_t S_TAIL = S_FIN;
   assign chk_st = 1'b0;
`endif

   assign bs.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                          (state == S_DATA) || chk_st;
   assign wr_en         = (state == S_WRITE);
   assign busy          = (state != S_IDLE);
   assign fetch_hold    = busy;
   assign enter_fin     = (state_nxt == S_FIN) && (state != S_FIN);

   byte_assembler u_asm (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (go),
      .shift (asm_shift),
      .din   (bs.byte_in),
      .word  (wr_data),
      .full  (asm_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fin_err   = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_LEN_HI;
         S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
         S_LEN_LO: if (xfer) begin
            if (len_in == '0) begin
               state_nxt = S_TAIL;
            end else if (32'(len_in) > DEPTH_U) begin
               state_nxt = S_FIN;
               fin_err   = 1'b1;
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_DATA:   if (asm_full) state_nxt = S_WRITE;
         S_WRITE:  state_nxt = last_word ? S_TAIL : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK: if (xfer) begin
            state_nxt = S_FIN;
            fin_err   = (csum ^ bs.byte_in) != 8'h00;
         end
`endif
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // done/err are decided on the edge into FIN and then hold until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len        <= '0;
         word_count <= '0;
         wr_addr    <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (go) begin
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
         end
         if (xfer && (state == S_LEN_HI)) len[LEN_W-1:8] <= bs.byte_in;
         if (xfer && (state == S_LEN_LO)) len <= len_in;
         if (asm_full) wr_addr <= BASE_ADDR + {14'd0, word_count, 2'b00};
         if (state == S_WRITE) word_count <= word_count + 16'd1;
         if (enter_fin) begin
            done <= !fin_err;
            err  <= fin_err;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed and random length-prefixed loads
// checked against a stream-level reference model.
module tb_imem_loader;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 64;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        wr_en, busy, fetch_hold, done, err;
   logic [31:0] wr_addr, wr_data;
   logic [15:0] word_count;

   imem_loader_if bs ();

   imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bs         (bs),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .fetch_hold (fetch_hold),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int  total = 0;
   int  bad = 0;
   int  wr_seen = 0;
   wr_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         wr_seen++;
         chk("ready_low_in_write", 32'(bs.byte_ready), 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   task automatic append_chk(inout byte_q_t s, input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      foreach (s[i]) x ^= s[i];
      s.push_back(corrupt ? ~x : x);
`else
      if (corrupt) s = s;
`endif
   endtask

   // Reference model: parse the stream, queue expected writes, predict status.
   task automatic model(input byte_q_t s, output int nw, output bit e);
      int n;
      n  = int'({s[0], s[1]});
      nw = 0;
      e  = 1'b0;
      if (n > DEPTH) begin
         e = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++)
         exp_q.push_back({BASE + 32'(4 * i),
                          s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      nw = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'h00;
         foreach (s[i]) x ^= s[i];
         e = (x != 8'h00);
      end
`endif
   endtask

   task automatic make_stream(input int n, input bit corrupt, output byte_q_t s);
      s = {};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= DEPTH) begin
         for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
         append_chk(s, corrupt);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
      int t;
      bs.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bs.byte_in    = b;
      bs.byte_valid = 1'b1;
      start         = poke_start;
      t = 0;
      while (!bs.byte_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("handshake_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bs.byte_valid = 1'b0;
      start         = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_load(input byte_q_t s, input int gmode, input bit fin_start,
                           input int max_done_cyc, input string tag);
      int nw, cyc, seen0, g;
      bit e;
      model(s, nw, e);
      seen0 = wr_seen;
      start_pulse();
      chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      chk({tag, "_hold_rise"}, 32'(fetch_hold), 32'd1);
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      foreach (s[i]) begin
         g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 3));
         send_byte(s[i], g, (i >= 2) && ($urandom_range(0, 3) == 0));
      end
      if (fin_start) start_pulse();
      cyc = 0;
      while (!done && !err && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_latency"}, 32'(cyc <= max_done_cyc), 32'd1);
      cyc = 0;
      while (busy && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
      chk({tag, "_hold_fall"}, 32'(fetch_hold), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'(!e));
      chk({tag, "_err"}, 32'(err), 32'(e));
      chk({tag, "_word_count"}, 32'(word_count), 32'(nw));
      chk({tag, "_writes"}, 32'(wr_seen - seen0), 32'(nw));
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hold"}, 32'(fetch_hold), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_ready"}, 32'(bs.byte_ready), 32'd0);
      chk({tag, "_wr_addr"}, wr_addr, 32'd0);
      chk({tag, "_wr_data"}, wr_data, 32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t s;
      int n;
      bs.byte_in    = 8'h00;
      bs.byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;
      @(negedge clk);

      s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
      append_chk(s, 1'b0);
      run_load(s, 0, 1'b0, 20, "two_words");

      s = '{8'h00, 8'h00};
      append_chk(s, 1'b0);
      run_load(s, 0, 1'b0, 3, "zero_len");

      s = '{8'h00, 8'h41};
      run_load(s, 0, 1'b1, 3, "too_long");

      make_stream(1, 1'b0, s);
      run_load(s, 1, 1'b0, 20, "toggle_valid");

      // Abort mid-word: outputs must drop to reset values without a clock edge.
      start_pulse();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'hA5, 0, 1'b0);
      send_byte(8'h5A, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      make_stream(3, 1'b0, s);
      run_load(s, 0, 1'b0, 20, "after_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
      s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h12};
      run_load(s, 0, 1'b0, 20, "chk_good");
      s = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
      run_load(s, 0, 1'b0, 20, "chk_bad");
`endif

      make_stream(DEPTH, 1'b0, s);
      run_load(s, 0, 1'b0, 20, "full_depth");

      for (int k = 0; k < 8; k++) begin
         if (k == 0)      n = int'($urandom_range(DEPTH + 1, 65535));
         else if (k == 1) n = 0;
         else             n = int'($urandom_range(1, 8));
         make_stream(n, $urandom_range(0, 3) == 0, s);
         run_load(s, int'($urandom_range(0, 2)), 1'b0, 20, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
